main_decoder: RTL and testbench
===============================

MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high. Port names: clk, rst.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; only the sticky flag register uses it.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset of the sticky flag register.
REQ-004 SHALL have port: Op  input  7  instruction opcode field, instr[6:0].
REQ-005 SHALL have port: RegWrite  output  1  register-file write enable.
REQ-006 SHALL have port: ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port: ALUSrc  output  1  ALU operand B select: 0 register, 1 immediate.
REQ-008 SHALL have port: MemWrite  output  1  data-memory write enable.
REQ-009 SHALL have port: ResultSrc  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
REQ-010 SHALL have port: Branch  output  1  conditional-branch instruction.
REQ-011 SHALL have port: Jump  output  1  unconditional jump (JAL).
REQ-012 SHALL have port: ALUOp  output  2  ALU class: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-013 SHALL have port: IllegalOp  output  1  current Op is not a supported opcode (combinational).
REQ-014 SHALL have port: IllegalSticky  output  1  registered flag; set once any illegal Op has been sampled.

Function
REQ-015 All outputs except IllegalSticky SHALL be purely combinational functions of Op. They SHALL have zero latency and SHALL be independent of clk and rst.
REQ-016 Decode table, in the order RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp:
- LOAD 0000011: 1, 00, 1, 0, 01, 0, 0, 00.
- STORE 0100011: 0, 01, 1, 1, 00, 0, 0, 00.
- R-type 0110011: 1, 00, 0, 0, 00, 0, 0, 10.
- I-type ALU 0010011: 1, 00, 1, 0, 00, 0, 0, 10.
- BRANCH 1100011: 0, 10, 0, 0, 00, 1, 0, 01.
- JAL 1101111: 1, 11, 0, 0, 10, 0, 1, 00.
REQ-017 Any other Op, including 1111111, 0000000 and X/Z bits, SHALL drive all decode outputs to 0 and IllegalOp to 1. All-zero is the safe default: no register write and no memory write.
REQ-018 IllegalOp SHALL be 0 for exactly the six opcodes of REQ-016.
REQ-019 "Don't care" fields SHALL still be driven to the listed values, never X. Example: ResultSrc=00 for STORE and BRANCH.
REQ-020 IllegalSticky SHALL set to 1 on a rising clk edge where IllegalOp=1, and SHALL hold 1 until rst.
REQ-021 When IllegalOp=1 and rst=1 occur together, rst SHALL win and IllegalSticky SHALL be 0.

Reset
REQ-022 rst=1 SHALL force IllegalSticky to 0 immediately, without waiting for clk.
REQ-023 rst SHALL NOT affect any combinational output; decoding SHALL be valid even while rst is asserted or undriven.

Structure
REQ-024 Opcode constants (LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL) and the ImmSrc, ResultSrc and ALUOp encodings SHALL live in the shared processor package.
REQ-025 The block SHALL be a single module, with the decode implemented as one case statement that has a default branch.
REQ-026 The only state in the block SHALL be the one-bit sticky flip-flop; no sub-module is required.

Verification
REQ-027 Op=0000011 -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, Branch=0, ALUOp=00, IllegalOp=0.
REQ-028 Op=0100011 -> RegWrite=0, ImmSrc=01, ALUSrc=1, MemWrite=1, ResultSrc=00, Branch=0, ALUOp=00.
REQ-029 Op=0110011 -> RegWrite=1, ALUSrc=0, ALUOp=10. Op=1100011 -> ImmSrc=10, Branch=1, ALUOp=01, RegWrite=0.
REQ-030 Op=1101111 -> Jump=1, ImmSrc=11, ResultSrc=10, RegWrite=1. Op=0010011 -> ALUSrc=1, ALUOp=10.
REQ-031 Op=1111111 -> all decode outputs 0 and IllegalOp=1 within 1 ns; after one clk edge IllegalSticky=1; the flag stays 1 after Op returns to 0110011.
REQ-032 Assert rst mid-cycle while IllegalSticky=1 -> flag clears without a clk edge; combinational outputs do not change.

Source files
------------

// File: rtl/main_decoder_pkg.sv
// rtl/main_decoder_pkg.sv - shared processor opcode and control-encoding constants
package main_decoder_pkg;

    // Base-ISA major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Writeback source select
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - opcode main decoder with sticky illegal-opcode flag
module main_decoder
    import main_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic       Branch,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic       IllegalOp,
    output logic       IllegalSticky
);

    // Decode Op into control signals; anything unrecognised (including X/Z) falls to an all-zero safe default
    always_comb begin
        RegWrite  = 1'b0;
        ImmSrc    = IMM_I;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = RES_ALU;
        Branch    = 1'b0;
        Jump      = 1'b0;
        ALUOp     = ALU_ADD;
        IllegalOp = 1'b0;
        case (Op)
            OP_LOAD: begin
                RegWrite  = 1'b1;
                ImmSrc    = IMM_I;
                ALUSrc    = 1'b1;
                ResultSrc = RES_MEM;
                ALUOp     = ALU_ADD;
            end
            OP_STORE: begin
                ImmSrc    = IMM_S;
                ALUSrc    = 1'b1;
                MemWrite  = 1'b1;
                ALUOp     = ALU_ADD;
            end
            OP_RTYPE: begin
                RegWrite  = 1'b1;
                ALUOp     = ALU_FUNCT;
            end
            OP_ITYPE: begin
                RegWrite  = 1'b1;
                ImmSrc    = IMM_I;
                ALUSrc    = 1'b1;
                ALUOp     = ALU_FUNCT;
            end
            OP_BRANCH: begin
                ImmSrc    = IMM_B;
                Branch    = 1'b1;
                ALUOp     = ALU_SUB;
            end
            OP_JAL: begin
                RegWrite  = 1'b1;
                ImmSrc    = IMM_J;
                ResultSrc = RES_PC4;
                Jump      = 1'b1;
            end
            default: begin
                IllegalOp = 1'b1;
            end
        endcase
    end

    // Remember that an illegal opcode was ever sampled; only reset clears it, and reset wins over a same-edge set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IllegalSticky <= 1'b0;
        end else if (IllegalOp) begin
            IllegalSticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_main_decoder.sv
// tb/tb_main_decoder.sv - randomized scoreboard bench for main_decoder
module tb_main_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Branch;
    logic       Jump;
    logic [1:0] ALUOp;
    logic       IllegalOp;
    logic       IllegalSticky;

    main_decoder dut (
        .clk(clk), .rst(rst), .Op(Op),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .MemWrite(MemWrite), .ResultSrc(ResultSrc), .Branch(Branch),
        .Jump(Jump), .ALUOp(ALUOp), .IllegalOp(IllegalOp),
        .IllegalSticky(IllegalSticky)
    );

    always #5 clk = ~clk;

    // {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp, IllegalOp}
    typedef struct {
        logic [6:0]  op;
        logic [11:0] dec;
        logic        sticky;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] ref_tbl[logic [6:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_sticky;
    logic [6:0]  prev_op;
    logic        stim_done = 1'b0;

    function automatic logic [11:0] ref_dec(input logic [6:0] op);
        if (ref_tbl.exists(op)) return ref_tbl[op];
        return 12'b0000_0000_0001;
    endfunction

    function automatic logic [11:0] dut_vec();
        return {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp, IllegalOp};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Drive one opcode just after a rising edge and queue what the monitor should see mid-cycle
    task automatic drive(input logic [6:0] op);
        exp_t e;
        @(posedge clk);
        if (!rst && ref_dec(prev_op)[0]) model_sticky = 1'b1;
        #1;
        Op      = op;
        prev_op = op;
        e.op     = op;
        e.dec    = ref_dec(op);
        e.sticky = model_sticky;
        sb_q.push_back(e);
    endtask

    // Monitor: on each falling edge, compare DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("decode op=%b", e.op), dut_vec(), e.dec);
                check($sformatf("sticky op=%b", e.op), {11'b0, IllegalSticky}, {11'b0, e.sticky});
            end
        end
    end

    initial begin
        exp_t        e;
        logic [11:0] held;
        logic [6:0]  legal[6];

        ref_tbl[7'b0000011] = 12'b1_00_1_0_01_0_0_00_0;
        ref_tbl[7'b0100011] = 12'b0_01_1_1_00_0_0_00_0;
        ref_tbl[7'b0110011] = 12'b1_00_0_0_00_0_0_10_0;
        ref_tbl[7'b0010011] = 12'b1_00_1_0_00_0_0_10_0;
        ref_tbl[7'b1100011] = 12'b0_10_0_0_00_1_0_01_0;
        ref_tbl[7'b1101111] = 12'b1_11_0_0_10_0_1_00_0;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

        // Reset state: decode valid during reset, flag clear
        rst          = 1'b1;
        Op           = 7'b0000011;
        prev_op      = Op;
        model_sticky = 1'b0;
        e.op = Op; e.dec = ref_dec(Op); e.sticky = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1 rst = 1'b0;

        // Every legal opcode, then an illegal one that arms the flag, then back to legal
        foreach (legal[i]) drive(legal[i]);
        drive(7'b1111111);
        drive(7'b0110011);
        drive(7'b0110011);
        drive(7'b0000000);

        // Mid-cycle reset clears the flag without a clock edge; decode unchanged
        drive(7'b0010011);
        #5;
        held = dut_vec();
        rst  = 1'b1;
        #1;
        check("async rst clears sticky", {11'b0, IllegalSticky}, 12'b0);
        check("rst leaves decode", dut_vec(), held);
        check("rst decode vs model", dut_vec(), ref_dec(7'b0010011));
        model_sticky = 1'b0;
        #1 rst = 1'b0;
        drive(7'b1100011);
        drive(7'b1100011);

        // Illegal Op sampled while rst held: reset wins
        drive(7'b1111111);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst wins over illegal", {11'b0, IllegalSticky}, 12'b0);
        Op           = 7'b0000011;
        prev_op      = Op;
        model_sticky = 1'b0;
        #1 rst = 1'b0;
        drive(7'b0100011);
        drive(7'b1101111);

        // Randomized mix of legal and arbitrary opcodes, with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) drive(legal[$urandom_range(0, 5)]);
            else                           drive(7'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                #5 rst = 1'b1;
                #1;
                check("random async rst", {11'b0, IllegalSticky}, 12'b0);
                model_sticky = 1'b0;
                #1 rst = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard drained", 12'(sb_q.size()), 12'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
